prbs_chk_1b: RTL and testbench
==============================

Name: prbs_chk_1b

Overview:
Serial 1-bit PRBS checker and error counter. It is the receive-side partner of the team's 1-bit PRBS/toggle pattern generator.
It self-synchronises to PRBS7/10/15/31 or a toggle stream, declares lock, then free-runs a local reference and counts bit errors.
Sits at the capture output of the ADC/serial data path, used for BER measurement and ML training data qualification.

Parameters:
LOCK_CNT, 64, consecutive correct predictions in HUNT required to declare lock (>=1)
LOSS_WIN, 256, bits per loss-of-lock observation window in LOCK
LOSS_THR, 32, errors within one window that force relock (1..LOSS_WIN)
CNT_W, 32, width of err_cnt and bit_cnt

Ports:
clk  input  1  clock
arstb  input  1  reset, asynchronous, active-low
rstb  input  1  synchronous reset, active-low; same effect as arstb
chk_en  input  1  1: checker runs; 0: hold in IDLE, counters frozen
prbs_en  input  1  1: PRBS check; 0: toggle-pattern check
inv  input  1  1: invert received data before checking
ptrn_sel  input  2  00 PRBS7, 01 PRBS10, 10 PRBS15, 11 PRBS31
clr_cnt  input  1  synchronous clear of err_cnt and bit_cnt (one-cycle pulse or level)
din  input  1  received serial bit, one per clk
lock  output  1  1 while in LOCK state
err  output  1  one-cycle pulse per mismatched bit in LOCK
err_cnt  output  CNT_W  saturating count of errors while locked
bit_cnt  output  CNT_W  saturating count of bits checked while locked

Behaviour:
- Reset (arstb low, or rstb low at an edge):
  - state=IDLE, lock=0, err=0, err_cnt=0, bit_cnt=0.
  - History register, window counters and the input flop are cleared.
- Input stage: d_q <= din ^ inv, registered every cycle. All checking uses d_q.
- Recurrence, on the bit sequence x:
  - PRBS7: x[n]=x[n-7]^x[n-6]. PRBS10: x[n]=x[n-10]^x[n-7]. PRBS15: x[n]=x[n-15]^x[n-14]. PRBS31: x[n]=x[n-31]^x[n-28].
  - Toggle: x[n]=~x[n-1], with order N=1.
  - N = order of the selected pattern. 31-bit history register h; predicted bit p is computed from h.
- States:
  - IDLE: entered when chk_en=0. Moves to SEED on the cycle after chk_en=1.
  - SEED: shift d_q into h for N bits, with no compare. Then go to HUNT with run counter=0.
  - HUNT: compare d_q with p and shift d_q into h.
    - Match: run+1. Mismatch: run=0, stay in HUNT.
    - When run reaches LOCK_CNT, go to LOCK. lock=1 from the next cycle.
  - LOCK: shift p into h (local free-run, not d_q).
    - mismatch(d_q != p) -> err=1 on the next cycle, err_cnt+1.
    - bit_cnt+1 every LOCK cycle.
    - Window counter counts LOCK bits modulo LOSS_WIN and tracks window errors.
    - Window errors reaching LOSS_THR -> go to SEED, lock=0 next cycle.
    - An error on the last bit of a window counts toward that window before the window count resets.
- Latency: a bit on din at edge t is in d_q after t. Its err pulse is registered at edge t+1 and visible for the cycle after t+1.
- Configuration change: any change of ptrn_sel, prbs_en or inv, detected against registered copies, forces SEED on the next edge. lock drops and counters hold.
- chk_en=0 in any state: go to IDLE, lock=0. Counters hold their value; they are not cleared.
- Counter rules:
  - err_cnt and bit_cnt saturate at all-ones and never wrap.
  - clr_cnt has priority over increment in the same cycle: result is 0.
  - clr_cnt does not affect state or lock.
- Simultaneous events: rstb > chk_en=0 > configuration change > loss-of-lock > normal operation.
- Error multiplication: none in LOCK. One flipped din bit gives exactly one err pulse. HUNT is self-synchronising, so errors there only restart the run count.

Test Plan:
1. Generator PRBS7, checker ptrn_sel=00, chk_en=1, clean link -> lock rises after 7 SEED + 64 HUNT bits plus pipeline; over 10000 further bits err_cnt=0 and bit_cnt=10000.
2. PRBS15 locked, flip din at a single bit -> exactly one err pulse 2 edges later, err_cnt=1, lock stays 1.
3. Generator inv=0, checker inv=1, PRBS7 -> a complemented 2-tap sequence always mispredicts, so lock stays 0 indefinitely and err_cnt=0.
4. PRBS31 locked, inject 40 errors within 256 bits -> lock drops on the cycle after the 32nd error, err_cnt=32, relock 31+64 bits after errors cease.
5. Locked on PRBS10, switch generator and checker to ptrn_sel=11 -> lock=0 next cycle, relock on PRBS31, counters retained; then pulse clr_cnt -> both counters 0.
6. prbs_en=0 toggle stream -> lock after 1+64 bits. With err_cnt preloaded near all-ones (CNT_W=4 build), continuous errors hold err_cnt at 15 until loss-of-lock, with no wrap. Assert arstb mid-LOCK -> all outputs 0 immediately.

Source files
------------

// File: rtl/prbs_chk_1b.sv
// prbs_chk_1b: serial 1-bit PRBS / toggle-pattern checker with BER counters.
// Self-synchronises on the received stream (SEED + HUNT), then free-runs a
// local reference in LOCK and counts mismatches against it.
module prbs_chk_1b #(
   parameter int LOCK_CNT = 64,
   parameter int LOSS_WIN = 256,
   parameter int LOSS_THR = 32,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             arstb,
   input  logic             rstb,
   input  logic             chk_en,
   input  logic             prbs_en,
   input  logic             inv,
   input  logic [1:0]       ptrn_sel,
   input  logic             clr_cnt,
   input  logic             din,
   output logic             lock,
   output logic             err,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] bit_cnt
);

   localparam int RUN_W = $clog2(LOCK_CNT + 1);
   // Window counters also have to hold LOSS_THR (which is <= LOSS_WIN).
   localparam int WIN_W = $clog2(LOSS_WIN + 1);

   typedef enum logic [1:0] {S_IDLE, S_SEED, S_HUNT, S_LOCK} state_t;

   state_t           state;
   logic             d_q;
   logic [1:0]       ptrn_q;
   logic             prbs_q;
   logic             inv_q;
   logic [30:0]      h;
   logic [4:0]       seed_cnt;
   logic [RUN_W-1:0] run_cnt;
   logic [WIN_W-1:0] win_cnt;
   logic [WIN_W-1:0] win_err;

   logic             p;
   logic [4:0]       ord_m1;
   logic             mism;
   logic             cfg_chg;
   logic [WIN_W-1:0] win_err_nxt;
   logic             cnt_run;
   logic             err_inc;

   // Saturating increment: counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Predicted next bit from history (h[0] is the newest bit) and the order-1 of the pattern.
   always_comb begin
      p      = ~h[0];
      ord_m1 = 5'd0;
      if (prbs_q) begin
         case (ptrn_q)
            2'b00:   begin p = h[6]  ^ h[5];  ord_m1 = 5'd6;  end
            2'b01:   begin p = h[9]  ^ h[6];  ord_m1 = 5'd9;  end
            2'b10:   begin p = h[14] ^ h[13]; ord_m1 = 5'd14; end
            default: begin p = h[30] ^ h[27]; ord_m1 = 5'd30; end
         endcase
      end
   end

   assign mism        = d_q ^ p;
   assign cfg_chg     = (ptrn_sel != ptrn_q) | (prbs_en != prbs_q) | (inv != inv_q);
   assign win_err_nxt = win_err + WIN_W'(mism);
   // Counters only advance on a normal LOCK cycle (not disabled, no reconfiguration).
   assign cnt_run     = chk_en & ~cfg_chg & (state == S_LOCK);
   assign err_inc     = cnt_run & mism;

   // Input flop (optionally inverted) and registered copies of the configuration.
   always_ff @(posedge clk or negedge arstb) begin
      if (!arstb) begin
         d_q    <= 1'b0;
         ptrn_q <= 2'b00;
         prbs_q <= 1'b0;
         inv_q  <= 1'b0;
      end else if (!rstb) begin
         d_q    <= 1'b0;
         ptrn_q <= 2'b00;
         prbs_q <= 1'b0;
         inv_q  <= 1'b0;
      end else begin
         d_q    <= din ^ inv;
         ptrn_q <= ptrn_sel;
         prbs_q <= prbs_en;
         inv_q  <= inv;
      end
   end

   // Sync FSM: seed history, hunt for LOCK_CNT good predictions, then free-run and watch for loss.
   always_ff @(posedge clk or negedge arstb) begin
      if (!arstb) begin
         state    <= S_IDLE;
         lock     <= 1'b0;
         err      <= 1'b0;
         h        <= '0;
         seed_cnt <= '0;
         run_cnt  <= '0;
         win_cnt  <= '0;
         win_err  <= '0;
      end else if (!rstb) begin
         state    <= S_IDLE;
         lock     <= 1'b0;
         err      <= 1'b0;
         h        <= '0;
         seed_cnt <= '0;
         run_cnt  <= '0;
         win_cnt  <= '0;
         win_err  <= '0;
      end else begin
         err <= 1'b0;
         if (!chk_en) begin
            state <= S_IDLE;
            lock  <= 1'b0;
         end else if (cfg_chg) begin
            state    <= S_SEED;
            seed_cnt <= '0;
            lock     <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  state    <= S_SEED;
                  seed_cnt <= '0;
               end
               S_SEED: begin
                  h <= {h[29:0], d_q};
                  if (seed_cnt == ord_m1) begin
                     state   <= S_HUNT;
                     run_cnt <= '0;
                  end else begin
                     seed_cnt <= seed_cnt + 5'd1;
                  end
               end
               S_HUNT: begin
                  h <= {h[29:0], d_q};
                  if (mism) begin
                     run_cnt <= '0;
                  end else if (run_cnt == RUN_W'(LOCK_CNT - 1)) begin
                     state   <= S_LOCK;
                     lock    <= 1'b1;
                     win_cnt <= '0;
                     win_err <= '0;
                  end else begin
                     run_cnt <= run_cnt + RUN_W'(1);
                  end
               end
               default: begin
                  // Free-run on the prediction so a line error cannot corrupt the reference.
                  h   <= {h[29:0], p};
                  err <= mism;
                  if (win_err_nxt >= WIN_W'(LOSS_THR)) begin
                     state    <= S_SEED;
                     seed_cnt <= '0;
                     lock     <= 1'b0;
                  end else if (win_cnt == WIN_W'(LOSS_WIN - 1)) begin
                     win_cnt <= '0;
                     win_err <= '0;
                  end else begin
                     win_cnt <= win_cnt + WIN_W'(1);
                     win_err <= win_err_nxt;
                  end
               end
            endcase
         end
      end
   end

   // Saturating error and bit counters; clear wins over increment.
   always_ff @(posedge clk or negedge arstb) begin
      if (!arstb) begin
         err_cnt <= '0;
         bit_cnt <= '0;
      end else if (!rstb) begin
         err_cnt <= '0;
         bit_cnt <= '0;
      end else if (clr_cnt) begin
         err_cnt <= '0;
         bit_cnt <= '0;
      end else begin
         if (cnt_run) bit_cnt <= sat_inc(bit_cnt);
         if (err_inc) err_cnt <= sat_inc(err_cnt);
      end
   end

endmodule

// File: tb/tb_prbs_chk_1b.sv
// Bench for prbs_chk_1b: pattern table, hand-written corner sequences and a
// randomized run compared against a sequence-level reference model.
module tb_prbs_chk_1b;
   localparam int LOCK_CNT = 64;
   localparam int LOSS_WIN = 256;
   localparam int LOSS_THR = 32;
   localparam int CNT_W    = 32;

   logic             clk = 1'b0;
   logic             arstb = 1'b0;
   logic             rstb = 1'b0;
   logic             chk_en = 1'b0;
   logic             prbs_en = 1'b1;
   logic             inv = 1'b0;
   logic [1:0]       ptrn_sel = 2'b00;
   logic             clr_cnt = 1'b0;
   logic             din = 1'b0;
   logic             lock, err, lock_s, err_s;
   logic [CNT_W-1:0] err_cnt, bit_cnt;
   logic [3:0]       err_cnt_s, bit_cnt_s;

   int n_cmp = 0;
   int n_bad = 0;
   int err_seen = 0;
   bit mon_en = 1'b0;

   always #5 clk = ~clk;

   prbs_chk_1b #(.LOCK_CNT(LOCK_CNT), .LOSS_WIN(LOSS_WIN), .LOSS_THR(LOSS_THR), .CNT_W(CNT_W)) dut (
      .clk(clk), .arstb(arstb), .rstb(rstb), .chk_en(chk_en), .prbs_en(prbs_en), .inv(inv),
      .ptrn_sel(ptrn_sel), .clr_cnt(clr_cnt), .din(din), .lock(lock), .err(err),
      .err_cnt(err_cnt), .bit_cnt(bit_cnt));

   prbs_chk_1b #(.LOCK_CNT(LOCK_CNT), .LOSS_WIN(LOSS_WIN), .LOSS_THR(LOSS_THR), .CNT_W(4)) dut_s (
      .clk(clk), .arstb(arstb), .rstb(rstb), .chk_en(chk_en), .prbs_en(prbs_en), .inv(inv),
      .ptrn_sel(ptrn_sel), .clr_cnt(clr_cnt), .din(din), .lock(lock_s), .err(err_s),
      .err_cnt(err_cnt_s), .bit_cnt(bit_cnt_s));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- pattern generator (transmit side) ----------------
   logic [63:0] gh = '1;
   logic [1:0]  g_sel = 2'b00;
   logic        g_prbs = 1'b1;
   logic        g_inv = 1'b0;
   int          flip_n = 0;

   // x[n-k] of the generated sequence
   function automatic logic xb(input int k);
      return gh[k-1];
   endfunction

   function automatic logic gen_bit();
      logic x;
      if (!g_prbs) x = ~xb(1);
      else begin
         case (g_sel)
            2'b00:   x = xb(7)  ^ xb(6);
            2'b01:   x = xb(10) ^ xb(7);
            2'b10:   x = xb(15) ^ xb(14);
            default: x = xb(31) ^ xb(28);
         endcase
      end
      gh = {gh[62:0], x};
      return x;
   endfunction

   // One clock per bit; the next line bit is driven 1 time unit after the edge.
   task automatic adv(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         err_seen += int'(err);
         din = gen_bit() ^ g_inv ^ (flip_n > 0);
         if (flip_n > 0) flip_n--;
      end
   endtask

   // Reset, configure both ends, then enable; returns 1 unit after edge E0.
   task automatic start_run(input logic [1:0] sel, input logic pen, input logic ginv, input logic cinv);
      chk_en = 1'b0; rstb = 1'b0; clr_cnt = 1'b0;
      ptrn_sel = sel; prbs_en = pen; inv = cinv;
      g_sel = sel; g_prbs = pen; g_inv = ginv; flip_n = 0;
      gh = {$urandom, $urandom} | 64'h1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rstb = 1'b1;
      @(posedge clk); #1;
      chk_en = 1'b1;
      din = gen_bit() ^ g_inv;
      err_seen = 0;
   endtask

   // ---------------- reference model ----------------
   typedef enum {M_IDLE, M_SEED, M_HUNT, M_LOCK} mst_t;
   mst_t       ms = M_IDLE;
   bit         mq[$];
   bit         md, mpen, minv, m_lock, m_err;
   logic [1:0] msel;
   int         mseed, mrun, mwb, mwe;
   longint     m_ec, m_bc;
   localparam longint CMAX = (64'd1 << CNT_W) - 1;

   // Tap pair and order of the recurrence x[n] = x[n-a] ^ x[n-b]
   task automatic taps(input logic [1:0] s, output int a, output int b, output int n);
      case (s)
         2'b00:   begin a = 7;  b = 6;  end
         2'b01:   begin a = 10; b = 7;  end
         2'b10:   begin a = 15; b = 14; end
         default: begin a = 31; b = 28; end
      endcase
      n = a;
   endtask

   // Model advances on every active edge using the inputs held stable across it.
   always @(posedge clk) begin
      bit pr, mm, chg, ec_i, bc_i;
      int ta, tb, n;
      if (!arstb || !rstb) begin
         ms = M_IDLE; mq = {};
         for (int i = 0; i < 31; i++) mq.push_front(1'b0);
         md = 0; msel = 0; mpen = 0; minv = 0; mseed = 0; mrun = 0; mwb = 0; mwe = 0;
         m_lock = 0; m_err = 0; m_ec = 0; m_bc = 0;
      end else begin
         taps(msel, ta, tb, n);
         if (mpen) pr = mq[ta-1] ^ mq[tb-1];
         else begin pr = ~mq[0]; n = 1; end
         mm = md ^ pr;
         chg = (ptrn_sel != msel) || (prbs_en != mpen) || (inv != minv);
         m_err = 0; ec_i = 0; bc_i = 0;
         if (!chk_en) begin ms = M_IDLE; m_lock = 0; end
         else if (chg) begin ms = M_SEED; mseed = 0; m_lock = 0; end
         else begin
            case (ms)
               M_IDLE: begin ms = M_SEED; mseed = 0; end
               M_SEED: begin
                  mq.push_front(md); mseed++;
                  if (mseed == n) begin ms = M_HUNT; mrun = 0; end
               end
               M_HUNT: begin
                  mq.push_front(md);
                  if (mm) mrun = 0;
                  else begin
                     mrun++;
                     if (mrun == LOCK_CNT) begin ms = M_LOCK; m_lock = 1; mwb = 0; mwe = 0; end
                  end
               end
               default: begin
                  mq.push_front(pr);
                  bc_i = 1; m_err = mm; ec_i = mm;
                  mwe += int'(mm); mwb++;
                  if (mwe >= LOSS_THR) begin ms = M_SEED; mseed = 0; m_lock = 0; end
                  else if (mwb == LOSS_WIN) begin mwb = 0; mwe = 0; end
               end
            endcase
         end
         while (mq.size() > 31) void'(mq.pop_back());
         if (clr_cnt) begin m_ec = 0; m_bc = 0; end
         else begin
            if (ec_i && m_ec < CMAX) m_ec++;
            if (bc_i && m_bc < CMAX) m_bc++;
         end
         msel = ptrn_sel; mpen = prbs_en; minv = inv; md = din ^ inv;
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         chk("rnd lock", 64'(lock), 64'(m_lock));
         chk("rnd err", 64'(err), 64'(m_err));
         chk("rnd err_cnt", 64'(err_cnt), 64'(m_ec));
         chk("rnd bit_cnt", 64'(bit_cnt), 64'(m_bc));
      end
   end

   // ---------------- stimulus ----------------
   typedef struct {
      logic [1:0] sel;
      logic       pen;
      logic       ginv;
      logic       cinv;
      int         lock_at;   // edges after E0 at which lock rises, 0 = never
      int         run;       // clean bits checked after lock
      string      name;
   } vec_t;

   vec_t vt[9];

   initial begin
      vt[0] = '{2'b00, 1'b1, 1'b0, 1'b0, 72, 10000, "prbs7"};
      vt[1] = '{2'b01, 1'b1, 1'b0, 1'b0, 75, 200,   "prbs10"};
      vt[2] = '{2'b10, 1'b1, 1'b0, 1'b0, 80, 200,   "prbs15"};
      vt[3] = '{2'b11, 1'b1, 1'b0, 1'b0, 96, 200,   "prbs31"};
      vt[4] = '{2'b00, 1'b0, 1'b0, 1'b0, 66, 200,   "toggle"};
      vt[5] = '{2'b00, 1'b1, 1'b0, 1'b1, 0,  0,     "prbs7 inv mismatch"};
      vt[6] = '{2'b00, 1'b1, 1'b1, 1'b1, 72, 200,   "prbs7 both inv"};
      vt[7] = '{2'b11, 1'b1, 1'b0, 1'b1, 0,  0,     "prbs31 inv mismatch"};
      vt[8] = '{2'b11, 1'b0, 1'b1, 1'b0, 66, 200,   "toggle gen inv"};

      // Reset state
      #12;
      chk("rst lock", 64'(lock), 0);
      chk("rst err", 64'(err), 0);
      chk("rst err_cnt", 64'(err_cnt), 0);
      chk("rst bit_cnt", 64'(bit_cnt), 0);
      #3 arstb = 1'b1;

      // Pattern table: lock latency, clean-link counters, never-lock cases
      foreach (vt[k]) begin
         start_run(vt[k].sel, vt[k].pen, vt[k].ginv, vt[k].cinv);
         if (vt[k].lock_at > 0) begin
            adv(vt[k].lock_at - 1);
            chk({vt[k].name, " lock early"}, 64'(lock), 0);
            adv(1);
            chk({vt[k].name, " lock"}, 64'(lock), 1);
            adv(vt[k].run);
            chk({vt[k].name, " err_cnt"}, 64'(err_cnt), 0);
            chk({vt[k].name, " bit_cnt"}, 64'(bit_cnt), 64'(vt[k].run));
            chk({vt[k].name, " err pulses"}, 64'(err_seen), 0);
            chk({vt[k].name, " lock held"}, 64'(lock), 1);
         end else begin
            adv(600);
            chk({vt[k].name, " no lock"}, 64'(lock), 0);
            chk({vt[k].name, " err_cnt"}, 64'(err_cnt), 0);
            chk({vt[k].name, " bit_cnt"}, 64'(bit_cnt), 0);
         end
      end

      // Single flipped bit while locked on PRBS15: one err pulse two edges later
      start_run(2'b10, 1'b1, 1'b0, 1'b0);
      adv(80);
      chk("flip1 lock", 64'(lock), 1);
      adv(20);
      flip_n = 1;
      adv(1);
      adv(1); chk("flip1 err t+1", 64'(err), 0);
      adv(1); chk("flip1 err t+2", 64'(err), 1);
      adv(1); chk("flip1 err t+3", 64'(err), 0);
      err_seen = 0;
      adv(50);
      chk("flip1 extra pulses", 64'(err_seen), 0);
      chk("flip1 err_cnt", 64'(err_cnt), 1);
      chk("flip1 bit_cnt", 64'(bit_cnt), 74);
      chk("flip1 lock held", 64'(lock), 1);

      // Error burst on PRBS31: loss of lock at the 32nd error, then relock
      start_run(2'b11, 1'b1, 1'b0, 1'b0);
      adv(96);
      chk("burst lock", 64'(lock), 1);
      flip_n = 40;
      adv(33);
      chk("burst lock before thr", 64'(lock), 1);
      chk("burst err_cnt 31", 64'(err_cnt), 31);
      adv(1);
      chk("burst lock lost", 64'(lock), 0);
      chk("burst err_cnt 32", 64'(err_cnt), 32);
      chk("burst bit_cnt", 64'(bit_cnt), 34);
      adv(200);
      chk("burst relock", 64'(lock), 1);
      chk("burst err_cnt held", 64'(err_cnt), 32);

      // Reconfigure PRBS10 -> PRBS31 while locked, counters retained, then clear
      start_run(2'b01, 1'b1, 1'b0, 1'b0);
      adv(75);
      chk("cfg lock p10", 64'(lock), 1);
      adv(50);
      ptrn_sel = 2'b11; g_sel = 2'b11;
      adv(1);
      chk("cfg lock drop", 64'(lock), 0);
      chk("cfg bit_cnt held", 64'(bit_cnt), 50);
      adv(94);
      chk("cfg relock early", 64'(lock), 0);
      adv(1);
      chk("cfg relock p31", 64'(lock), 1);
      adv(5);
      chk("cfg bit_cnt kept", 64'(bit_cnt), 55);
      clr_cnt = 1'b1;
      adv(1);
      clr_cnt = 1'b0;
      chk("clr bit_cnt", 64'(bit_cnt), 0);
      chk("clr err_cnt", 64'(err_cnt), 0);
      chk("clr lock", 64'(lock), 1);
      adv(1);
      chk("clr bit_cnt resume", 64'(bit_cnt), 1);

      // Toggle with 4-bit counters: saturation, loss of lock, async reset mid-LOCK
      start_run(2'b00, 1'b0, 1'b0, 1'b0);
      adv(65);
      chk("sat lock early", 64'(lock_s), 0);
      adv(1);
      chk("sat lock", 64'(lock_s), 1);
      flip_n = 40;
      adv(33);
      chk("sat err_cnt_s", 64'(err_cnt_s), 15);
      chk("sat err_cnt", 64'(err_cnt), 31);
      chk("sat lock held", 64'(lock_s), 1);
      adv(1);
      chk("sat lock lost", 64'(lock_s), 0);
      chk("sat err_cnt_s no wrap", 64'(err_cnt_s), 15);
      chk("sat bit_cnt_s", 64'(bit_cnt_s), 15);
      chk("sat err_cnt 32", 64'(err_cnt), 32);
      adv(200);
      chk("sat relock", 64'(lock), 1);
      @(posedge clk); #2;
      arstb = 1'b0;
      #1;
      chk("arst lock", 64'(lock), 0);
      chk("arst err_cnt", 64'(err_cnt), 0);
      chk("arst bit_cnt", 64'(bit_cnt), 0);
      chk("arst lock_s", 64'(lock_s), 0);
      chk("arst err_cnt_s", 64'(err_cnt_s), 0);
      #1 arstb = 1'b1;

      // Randomized run against the reference model
      chk_en = 1'b0; rstb = 1'b0; clr_cnt = 1'b0;
      g_sel = 2'b00; g_prbs = 1'b1; g_inv = 1'b0;
      ptrn_sel = 2'b00; prbs_en = 1'b1; inv = 1'b0; flip_n = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rstb = 1'b1; chk_en = 1'b1;
      mon_en = 1'b1;
      for (int c = 0; c < 6000; c++) begin
         @(posedge clk); #1;
         if ($urandom_range(0, 399) == 0) begin
            g_sel = 2'($urandom_range(0, 3));
            g_prbs = ($urandom_range(0, 3) != 0);
            g_inv = 1'($urandom_range(0, 1));
            ptrn_sel = g_sel; prbs_en = g_prbs;
            inv = ($urandom_range(0, 3) == 0) ? ~g_inv : g_inv;
         end
         if ($urandom_range(0, 199) == 0) flip_n = 1;
         if ($urandom_range(0, 1499) == 0) flip_n = 40;
         clr_cnt = ($urandom_range(0, 299) == 0);
         if (chk_en) chk_en = ($urandom_range(0, 699) != 0);
         else        chk_en = ($urandom_range(0, 4) == 0);
         din = gen_bit() ^ g_inv ^ (flip_n > 0);
         if (flip_n > 0) flip_n--;
      end
      @(negedge clk);
      mon_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
